// File: rtl/calc_pkg.sv
// calc_pkg: shared types and helpers for the calculator sequencer.
//   calc_state_e : entry FSM states
//   OP_ADD/OP_SUB: operator encodings held in op_r
//   calc_mag     : magnitude of a w-bit two's-complement value (w < CALC_MAX_W)
package calc_pkg;

    localparam int unsigned CALC_MAX_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HAVE_A  = 3'd1,
        HAVE_OP = 3'd2,
        HAVE_B  = 3'd3,
        EXEC    = 3'd4,
        RESULT  = 3'd5
    } calc_state_e;

    // val carries a w-bit value in its low bits. The negation is done at full
    // width and masked back, so the most-negative value maps to 2^(w-1).
    function automatic logic [CALC_MAX_W-1:0] calc_mag(input logic [CALC_MAX_W-1:0] val,
                                                       input int unsigned           w);
        logic [CALC_MAX_W-1:0] mask;
        logic [CALC_MAX_W-1:0] sign_bit;
        mask     = (CALC_MAX_W'(1) << w) - CALC_MAX_W'(1);
        sign_bit = CALC_MAX_W'(1) << (w - 1);
        if ((val & sign_bit) != '0) begin
            return (~val + CALC_MAX_W'(1)) & mask;
        end
        return val & mask;
    endfunction

endpackage

// File: rtl/calc_if.sv
// calc_if: strobe inputs and display outputs of the calculator sequencer.
//   master: input stage / bench side (drives strobes, reads display)
//   slave : calc_ctrl side
//   number/num_valid, op/op_valid, equal, clear : 1-cycle input strobes
//   SSD/sign : sign-magnitude display, c_out : overflow, busy : executing
interface calc_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] number;
    logic         num_valid;
    logic         op;
    logic         op_valid;
    logic         equal;
    logic         clear;
    logic [N-1:0] SSD;
    logic         sign;
    logic         c_out;
    logic         busy;

    modport master (
        output number, num_valid, op, op_valid, equal, clear,
        input  SSD, sign, c_out, busy
    );

    modport slave (
        input  number, num_valid, op, op_valid, equal, clear,
        output SSD, sign, c_out, busy
    );
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational N-bit two's-complement add/subtract.
//   a, b : operands      sub : 1 = a - b, 0 = a + b
//   sum  : wrapped result ovf : signed overflow
module calc_alu #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         ovf
);
    always_comb begin
        if (sub) begin
            sum = a - b;
            ovf = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
        end else begin
            sum = a + b;
            ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        end
    end
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: entry sequencer for the calculator accumulator path.
//   clk : system clock       rst : synchronous active-high reset
//   bus : calc_if.slave (operand/operator/equal/clear strobes in,
//         sign-magnitude display, c_out and busy out)
// Build option CALC_SUB_EN: when defined op=1 selects subtraction; when
// undefined the op input is ignored and every execute adds.
// N must stay below calc_pkg::CALC_MAX_W.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input logic   clk,
    input logic   rst,
    calc_if.slave bus
);
    calc_state_e  state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] b_q, b_d;
    logic         op_r_q, op_r_d;
    logic         c_out_q, c_out_d;

    logic         op_in;
    logic [N-1:0] alu_sum;
    logic         alu_ovf;
    logic [N-1:0] display;

`ifdef CALC_SUB_EN
    assign op_in = bus.op;
`else
    assign op_in = OP_ADD;
`endif

    calc_alu #(
        .N (N)
    ) u_alu (
        .a   (acc_q),
        .b   (b_q),
        .sub (op_r_q),
        .sum (alu_sum),
        .ovf (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            op_r_q  <= OP_ADD;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_r_q  <= op_r_d;
            c_out_q <= c_out_d;
        end
    end

    // Only the highest-priority strobe of a cycle is considered; the rest are
    // dropped even if the winner has no effect in the current state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_r_d  = op_r_q;
        c_out_d = c_out_q;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            b_d     = '0;
            op_r_d  = OP_ADD;
            c_out_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.equal && !bus.op_valid && bus.num_valid) begin
                        acc_d   = bus.number;
                        state_d = HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (bus.equal) begin
                        state_d = HAVE_A;
                    end else if (bus.op_valid) begin
                        op_r_d  = op_in;
                        state_d = HAVE_OP;
                    end else if (bus.num_valid) begin
                        acc_d = bus.number;
                    end
                end
                HAVE_OP: begin
                    if (bus.equal) begin
                        state_d = HAVE_OP;
                    end else if (bus.op_valid) begin
                        op_r_d = op_in;
                    end else if (bus.num_valid) begin
                        b_d     = bus.number;
                        state_d = HAVE_B;
                    end
                end
                HAVE_B: begin
                    if (bus.equal) begin
                        state_d = EXEC;
                    end else if (!bus.op_valid && bus.num_valid) begin
                        b_d = bus.number;
                    end
                end
                EXEC: begin
                    acc_d   = alu_sum;
                    c_out_d = alu_ovf;
                    state_d = RESULT;
                end
                RESULT: begin
                    if (bus.equal) begin
                        state_d = EXEC;
                    end else if (bus.op_valid) begin
                        op_r_d  = op_in;
                        state_d = HAVE_OP;
                    end else if (bus.num_valid) begin
                        acc_d   = bus.number;
                        c_out_d = 1'b0;
                        state_d = HAVE_A;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        display = acc_q;
        case (state_q)
            IDLE:    display = '0;
            HAVE_B:  display = b_q;
            default: display = acc_q;
        endcase
        bus.sign  = display[N-1];
        bus.SSD   = N'(calc_mag(CALC_MAX_W'(display), N));
        bus.c_out = c_out_q;
        bus.busy  = (state_q == EXEC);
    end
endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;
    localparam int unsigned N = 4;

    // Reference phases: what the user has entered so far.
    localparam int P_IDLE   = 0;
    localparam int P_A      = 1;
    localparam int P_OP     = 2;
    localparam int P_B      = 3;
    localparam int P_EXEC   = 4;
    localparam int P_RESULT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_if #(.N(N)) bus ();

    calc_ctrl #(
        .N (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state as plain signed integers.
    int m_phase = P_IDLE;
    int m_acc   = 0;
    int m_b     = 0;
    int m_sub   = 0;
    int m_ovf   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int u);
        return (u >= 8) ? u - 16 : u;
    endfunction

    function automatic int wrap4(input int v);
        return ((v + 8 + 32) % 16) - 8;
    endfunction

    task automatic model_update(input bit r, input bit c, input bit e, input bit ov,
                                input bit o, input bit nv, input int nm);
        int res;
        if (r || c) begin
            m_phase = P_IDLE;
            m_acc   = 0;
            m_b     = 0;
            m_sub   = 0;
            m_ovf   = 0;
        end else if (m_phase == P_EXEC) begin
            res     = m_sub ? (m_acc - m_b) : (m_acc + m_b);
            m_ovf   = (res > 7 || res < -8) ? 1 : 0;
            m_acc   = wrap4(res);
            m_phase = P_RESULT;
        end else if (e) begin
            if (m_phase == P_B || m_phase == P_RESULT) m_phase = P_EXEC;
        end else if (ov) begin
            if (m_phase == P_A || m_phase == P_OP || m_phase == P_RESULT) begin
`ifdef CALC_SUB_EN
                m_sub = o;
`else
                m_sub = 0;
`endif
                m_phase = P_OP;
            end
        end else if (nv) begin
            if (m_phase == P_IDLE || m_phase == P_A) begin
                m_acc   = to_signed(nm);
                m_phase = P_A;
            end else if (m_phase == P_RESULT) begin
                m_acc   = to_signed(nm);
                m_ovf   = 0;
                m_phase = P_A;
            end else begin
                m_b     = to_signed(nm);
                m_phase = P_B;
            end
        end
    endtask

    // One clock: drive strobes, let the edge happen, then compare all outputs.
    task automatic step(input bit r, input bit c, input bit e, input bit ov,
                        input bit o, input bit nv, input int nm);
        int disp;
        @(negedge clk);
        rst           = r;
        bus.clear     = c;
        bus.equal     = e;
        bus.op_valid  = ov;
        bus.op        = o;
        bus.num_valid = nv;
        bus.number    = 4'(nm);
        @(posedge clk);
        model_update(r, c, e, ov, o, nv, nm);
        #1;
        disp = (m_phase == P_IDLE) ? 0 : (m_phase == P_B) ? m_b : m_acc;
        check_eq("ssd",   int'(bus.SSD),   (disp < 0) ? -disp : disp);
        check_eq("sign",  int'(bus.sign),  (disp < 0) ? 1 : 0);
        check_eq("c_out", int'(bus.c_out), m_ovf);
        check_eq("busy",  int'(bus.busy),  (m_phase == P_EXEC) ? 1 : 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic num(input int v);
        step(0, 0, 0, 0, 0, 1, v);
    endtask

    task automatic oper(input bit o);
        step(0, 0, 0, 1, o, 0, 0);
    endtask

    task automatic eq();
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bus.number    = '0;
        bus.num_valid = 1'b0;
        bus.op        = 1'b0;
        bus.op_valid  = 1'b0;
        bus.equal     = 1'b0;
        bus.clear     = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_eq("rst_ssd", int'(bus.SSD), 0);

        // 3 + 4 = 7, busy for exactly the EXEC cycle
        num(3); oper(0); num(4);
        eq();
        check_eq("t1_busy", int'(bus.busy), 1);
        idle();
        check_eq("t1_ssd", int'(bus.SSD), 7);
        check_eq("t1_busy_off", int'(bus.busy), 0);

        // 5 + 6 overflows to -5
        num(5); oper(0); num(6); eq(); idle();
        check_eq("t2_ssd", int'(bus.SSD), 5);
        check_eq("t2_sign", int'(bus.sign), 1);
        check_eq("t2_cout", int'(bus.c_out), 1);

        // Repeat-equal and chaining
        num(2); oper(0); num(3); eq(); idle();
        check_eq("t3_first", int'(bus.SSD), 5);
        eq(); idle();
        check_eq("t3_mostneg", int'(bus.SSD), 8);
        check_eq("t3_cout", int'(bus.c_out), 1);
        oper(0); num(1); eq(); idle();
        check_eq("t3_chain", int'(bus.SSD), 7);
        check_eq("t3_chain_sign", int'(bus.sign), 1);
        check_eq("t3_chain_cout", int'(bus.c_out), 0);

        // Subtraction, or its absence
        step(0, 1, 0, 0, 0, 0, 0);
        num(2); oper(1); num(5); eq(); idle();
`ifdef CALC_SUB_EN
        check_eq("t4_sub_ssd", int'(bus.SSD), 3);
        check_eq("t4_sub_sign", int'(bus.sign), 1);
`else
        check_eq("t4_add_ssd", int'(bus.SSD), 7);
        check_eq("t4_add_sign", int'(bus.sign), 0);
`endif
        num(8); oper(1); num(1); eq(); idle();
`ifdef CALC_SUB_EN
        check_eq("t4_subovf_ssd", int'(bus.SSD), 7);
        check_eq("t4_subovf_cout", int'(bus.c_out), 1);
`else
        check_eq("t4_addneg_ssd", int'(bus.SSD), 7);
        check_eq("t4_addneg_cout", int'(bus.c_out), 0);
`endif

        // Priority
        num(2); oper(0); num(3);
        step(0, 1, 1, 0, 0, 0, 0);
        check_eq("t5_clear_ssd", int'(bus.SSD), 0);
        check_eq("t5_clear_busy", int'(bus.busy), 0);
        num(4);
        step(0, 0, 0, 1, 0, 1, 6);
        check_eq("t5_op_wins", int'(bus.SSD), 4);

        // rst during EXEC discards the computation
        num(1); oper(0); num(2); eq();
        step(1, 0, 1, 1, 1, 1, 7);
        check_eq("t6_rst_ssd", int'(bus.SSD), 0);
        check_eq("t6_rst_busy", int'(bus.busy), 0);
        // Strobes during EXEC ignored
        num(1); oper(0); num(2); eq();
        step(0, 0, 1, 1, 1, 1, 7);
        check_eq("t6_exec_ignore", int'(bus.SSD), 3);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
